// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fair fetch/data arbiter for a single-port 32-bit word memory
// Grants one transfer at a time, runs the memory handshake with timeout, returns a one-cycle ack.
module mem_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, RESP = 2'd2} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, next_state;
  logic              last_d;
  logic              sel_d;
  logic              we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic              grant_any, grant_d, addr_bad, timed_out;
  logic [31:0]       win_addr;
  logic              resp_fire, resp_d, resp_err;
  logic [31:0]       resp_data;

  // On a tie the port that was not served last wins; last_d resets to fetch.
  always_comb begin
    grant_any = i_req | d_req;
    grant_d   = d_req & (~i_req | ~last_d);
    win_addr  = grant_d ? d_addr : i_addr;
    addr_bad  = (win_addr[1:0] != 2'b00) || (win_addr[31:ADDR_W+2] != '0);
    timed_out = (wait_cnt == CNT_LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // resp_fire loads the granted port's response registers as the FSM enters RESP.
  always_comb begin
    next_state = state;
    resp_fire  = 1'b0;
    resp_d     = sel_d;
    resp_err   = 1'b0;
    resp_data  = '0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          resp_d = grant_d;
          if (addr_bad) begin
            next_state = RESP;
            resp_fire  = 1'b1;
            resp_err   = 1'b1;
          end else begin
            next_state = MEM;
          end
        end
      end
      MEM: begin
        if (mem_ack) begin
          next_state = RESP;
          resp_fire  = 1'b1;
          resp_data  = we_q ? '0 : mem_rdata;
        end else if (timed_out) begin
          next_state = RESP;
          resp_fire  = 1'b1;
          resp_err   = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_d   <= 1'b0;
      sel_d    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      i_ack    <= 1'b0;
      i_rdata  <= '0;
      i_err    <= 1'b0;
      d_ack    <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (state == IDLE && grant_any) begin
        sel_d   <= grant_d;
        addr_q  <= win_addr[ADDR_W+1:2];
        we_q    <= grant_d & d_we;
        be_q    <= (grant_d & d_we) ? d_be : 4'hF;
        wdata_q <= grant_d ? d_wdata : '0;
      end
      if (state == MEM && next_state == MEM) wait_cnt <= wait_cnt + 1'b1;
      else                                   wait_cnt <= '0;
      if (state == RESP) last_d <= sel_d;
      if (resp_fire) begin
        if (resp_d) begin
          d_ack   <= 1'b1;
          d_rdata <= resp_data;
          d_err   <= resp_err;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= resp_data;
          i_err   <= resp_err;
        end
      end
    end
  end

  assign mem_req   = (state == MEM);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 15;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              i_req, i_ack, i_err;
  logic [31:0]       i_addr, i_rdata;
  logic              d_req, d_we, d_ack, d_err;
  logic [3:0]        d_be;
  logic [31:0]       d_addr, d_wdata, d_rdata;
  logic              mem_req, mem_we, mem_ack;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic        port_d;
    logic [31:0] rdata;
    logic        err;
  } ack_t;

  typedef struct {
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } macc_t;

  ack_t        exp_ack[$];
  macc_t       exp_mem[$];
  ack_t        a_exp;
  macc_t       m_exp;
  logic [31:0] sim_mem [1024];
  logic [31:0] ref_mem [1024];
  int          n_checks = 0;
  int          n_fail = 0;
  int          mreq_cycles = 0;
  int          mem_delay = 0;
  bit          mem_never = 1'b0;
  int          wcnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // kind: 0 = normal read, 1 = address error (no memory cycle), 2 = timeout
  task automatic exp_read(input bit dport, input logic [31:0] addr, input int kind);
    ack_t  a;
    macc_t m;
    a.port_d = dport;
    a.rdata  = (kind == 0) ? ref_mem[addr[11:2]] : 32'h0;
    a.err    = (kind != 0);
    exp_ack.push_back(a);
    if (kind != 1) begin
      m.we = 1'b0; m.be = 4'hF; m.addr = addr[11:2]; m.wdata = 32'h0;
      exp_mem.push_back(m);
    end
  endtask

  task automatic exp_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    ack_t  a;
    macc_t m;
    m.we = 1'b1; m.be = be; m.addr = addr[11:2]; m.wdata = wd;
    exp_mem.push_back(m);
    a.port_d = 1'b1; a.rdata = 32'h0; a.err = 1'b0;
    exp_ack.push_back(a);
    ref_mem[addr[11:2]] = merge(ref_mem[addr[11:2]], wd, be);
  endtask

  // Memory model: answers after mem_delay cycles, checks each access on its first cycle.
  always @(negedge clock) begin
    if (!mem_req) begin
      wcnt    = 0;
      mem_ack = 1'b0;
    end else begin
      mreq_cycles++;
      if (wcnt == 0) begin
        if (exp_mem.size() == 0) check("mem_unexpected", 32'd1, 32'd0);
        else begin
          m_exp = exp_mem.pop_front();
          check("mem_we", 32'(mem_we), 32'(m_exp.we));
          check("mem_be", 32'(mem_be), 32'(m_exp.be));
          check("mem_addr", 32'(mem_addr), 32'(m_exp.addr));
          if (m_exp.we) check("mem_wdata", mem_wdata, m_exp.wdata);
        end
      end
      mem_ack   = !mem_never && (wcnt == mem_delay);
      mem_rdata = mem_ack ? sim_mem[mem_addr] : 32'hDEADBEEF;
      if (mem_ack && mem_we) sim_mem[mem_addr] = merge(sim_mem[mem_addr], mem_wdata, mem_be);
      wcnt++;
    end
  end

  // Response scoreboard
  always @(negedge clock) begin
    if (i_ack && d_ack) check("both_ack", 32'd1, 32'd0);
    if (i_ack || d_ack) begin
      if (exp_ack.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
      else begin
        a_exp = exp_ack.pop_front();
        check("ack_port", 32'(d_ack), 32'(a_exp.port_d));
        check(a_exp.port_d ? "d_rdata" : "i_rdata", a_exp.port_d ? d_rdata : i_rdata, a_exp.rdata);
        check(a_exp.port_d ? "d_err" : "i_err", 32'(a_exp.port_d ? d_err : i_err), 32'(a_exp.err));
      end
    end
  end

  // lat: cycle (1 = the IDLE cycle sampling req) in which ack is seen; -1 skips the check
  task automatic drive_i(input logic [31:0] addr, input int lat);
    int cyc;
    bit done;
    @(posedge clock); #1;
    i_addr = addr; i_req = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (i_ack) done = 1'b1;
    end
    check("i_ack_seen", 32'(done), 32'd1);
    if (lat >= 0) check("i_latency", 32'(cyc), 32'(lat));
    @(posedge clock); #1;
    i_req = 1'b0;
  endtask

  task automatic drive_d(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input int lat);
    int cyc;
    bit done;
    @(posedge clock); #1;
    d_addr = addr; d_we = we; d_be = be; d_wdata = wd; d_req = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (d_ack) done = 1'b1;
    end
    check("d_ack_seen", 32'(done), 32'd1);
    if (lat >= 0) check("d_latency", 32'(cyc), 32'(lat));
    @(posedge clock); #1;
    d_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ack_t  a;
    macc_t m;
    int    acks;
    int    cyc;
    for (int i = 0; i < 1024; i++) begin
      sim_mem[i] = 32'h5A000000 ^ (i * 32'h9E3779B1);
      ref_mem[i] = sim_mem[i];
    end
    sim_mem[2] = 32'h2010000A;
    ref_mem[2] = 32'h2010000A;
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_i_ack", 32'(i_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_err", 32'(d_err), 32'd0);
    reset_n = 1'b1;

    // single fetch, zero-wait memory
    exp_read(1'b0, 32'h8, 0);
    drive_i(32'h8, 3);
    check("t1_i_rdata_hold", i_rdata, 32'h2010000A);

    // simultaneous requests after reset: data wins, then fetch sees the written byte
    exp_write(32'h40, 4'b0001, 32'h11223355);
    exp_read(1'b0, 32'h40, 0);
    fork
      drive_d(32'h40, 1'b1, 4'b0001, 32'h11223355, 3);
      drive_i(32'h40, -1);
    join

    // both requests held: grants must alternate starting with data
    for (int k = 0; k < 3; k++) begin
      exp_read(1'b1, 32'h80, 0);
      exp_read(1'b0, 32'h84, 0);
    end
    @(posedge clock); #1;
    d_addr = 32'h80; d_we = 1'b0; i_addr = 32'h84;
    d_req = 1'b1; i_req = 1'b1;
    acks = 0; cyc = 0;
    while (acks < 6 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (i_ack || d_ack) acks++;
    end
    check("t5_ack_count", 32'(acks), 32'd6);
    @(posedge clock); #1;
    d_req = 1'b0; i_req = 1'b0;

    // address errors and the top valid word
    exp_read(1'b1, 32'h42, 1);
    drive_d(32'h42, 1'b0, 4'h0, 32'h0, 2);
    exp_read(1'b1, 32'h1000, 1);
    drive_d(32'h1000, 1'b0, 4'h0, 32'h0, 2);
    exp_read(1'b0, 32'h2, 1);
    drive_i(32'h2, 2);
    exp_read(1'b1, 32'hFFC, 0);
    drive_d(32'hFFC, 1'b0, 4'h0, 32'h0, 3);

    // timeout, then ack on the final allowed cycle
    mem_never = 1'b1;
    exp_read(1'b1, 32'h100, 2);
    mreq_cycles = 0;
    drive_d(32'h100, 1'b0, 4'h0, 32'h0, TIMEOUT + 2);
    check("t4_timeout_mreq_cycles", 32'(mreq_cycles), 32'(TIMEOUT));
    mem_never = 1'b0;
    mem_delay = TIMEOUT - 1;
    exp_read(1'b1, 32'h100, 0);
    mreq_cycles = 0;
    drive_d(32'h100, 1'b0, 4'h0, 32'h0, TIMEOUT + 2);
    check("t4_lastack_mreq_cycles", 32'(mreq_cycles), 32'(TIMEOUT));

    // write with no byte enables is issued but changes nothing
    mem_delay = 1;
    exp_write(32'h44, 4'b0000, 32'hFFFFFFFF);
    drive_d(32'h44, 1'b1, 4'b0000, 32'hFFFFFFFF, 4);
    mem_delay = 0;
    exp_read(1'b1, 32'h44, 0);
    drive_d(32'h44, 1'b0, 4'h0, 32'h0, 3);

    // reset in the middle of a memory cycle
    mem_never = 1'b1;
    m.we = 1'b0; m.be = 4'hF; m.addr = 10'd32; m.wdata = 32'h0;
    exp_mem.push_back(m);
    @(posedge clock); #1;
    d_addr = 32'h80; d_we = 1'b0; d_req = 1'b1;
    repeat (3) @(negedge clock);
    check("t6_in_mem", 32'(mem_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_mem_req", 32'(mem_req), 32'd0);
    check("t6_mem_addr", 32'(mem_addr), 32'd0);
    check("t6_d_ack", 32'(d_ack), 32'd0);
    check("t6_i_rdata", i_rdata, 32'd0);
    check("t6_d_rdata", d_rdata, 32'd0);
    mem_never = 1'b0;
    i_addr = 32'h84; i_req = 1'b1;
    exp_read(1'b1, 32'h80, 0);
    exp_read(1'b0, 32'h84, 0);
    @(negedge clock);
    reset_n = 1'b1;
    fork
      drive_d(32'h80, 1'b0, 4'h0, 32'h0, -1);
      drive_i(32'h84, -1);
    join

    repeat (5) @(negedge clock);
    check("exp_ack_left", 32'(exp_ack.size()), 32'd0);
    check("exp_mem_left", 32'(exp_mem.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
